store_buffer: RTL

Write-posting buffer between the core's data-memory port and the data bus. Full-word stores from the core are queued in a small in-order FIFO and drained to a variable-latency bus through a req/ack handshake. The core therefore retires stores in one cycle unless the buffer is full. A combinational forwarding path lets loads observe data that is still queued.

---
 rtl/store_buffer.sv | 100 ++++++++++
 1 files changed

// File: rtl/store_buffer.sv
// Write-posting store buffer: queues full-word core stores in an in-order FIFO,
// drains them over a req/ack bus, and forwards queued data to loads.
module store_buffer #(
   parameter int XLEN  = 32,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       n_rst,
   input  logic                       st_valid_i,
   input  logic [XLEN-1:0]            st_addr_i,
   input  logic [XLEN-1:0]            st_data_i,
   output logic                       full_o,
   output logic                       empty_o,
   output logic [$clog2(DEPTH):0]     count_o,
   output logic                       bus_req_o,
   output logic [XLEN-1:0]            bus_addr_o,
   output logic [XLEN-1:0]            bus_wdata_o,
   input  logic                       bus_ack_i,
   input  logic [XLEN-1:0]            ld_addr_i,
   output logic                       ld_hit_o,
   output logic [XLEN-1:0]            ld_data_o
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [XLEN-1:0] entryAddr_q [DEPTH];
   logic [XLEN-1:0] entryData_q [DEPTH];
   logic [PW-1:0]   headPtr_q, headPtr_d;
   logic [PW-1:0]   tailPtr_q, tailPtr_d;
   logic [CW-1:0]   count_q, count_d;

   logic full, empty, push, pop;

   // Flags come from the registered count only, so a same-cycle ack never frees a slot early.
   assign full  = (count_q == CW'(DEPTH));
   assign empty = (count_q == '0);
   assign push  = st_valid_i && !full;
   assign pop   = !empty && bus_ack_i;

   always_comb begin
      headPtr_d = headPtr_q;
      tailPtr_d = tailPtr_q;
      count_d   = count_q;
      if (push) begin
         tailPtr_d = tailPtr_q + 1'b1;
      end
      if (pop) begin
         headPtr_d = headPtr_q + 1'b1;
      end
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!n_rst) begin
         headPtr_q <= '0;
         tailPtr_q <= '0;
         count_q   <= '0;
      end else begin
         headPtr_q <= headPtr_d;
         tailPtr_q <= tailPtr_d;
         count_q   <= count_d;
      end
   end

   // Entry storage needs no reset: only slots covered by count are ever observed.
   always_ff @(posedge clk) begin
      if (n_rst && push) begin
         entryAddr_q[tailPtr_q] <= st_addr_i;
         entryData_q[tailPtr_q] <= st_data_i;
      end
   end

   assign full_o      = full;
   assign empty_o     = empty;
   assign count_o     = count_q;
   assign bus_req_o   = !empty;
   assign bus_addr_o  = empty ? '0 : entryAddr_q[headPtr_q];
   assign bus_wdata_o = empty ? '0 : entryData_q[headPtr_q];

   // Walk entries oldest to youngest so the last match is the youngest one.
   always_comb begin
      logic [PW-1:0] idx;
      idx       = '0;
      ld_hit_o  = 1'b0;
      ld_data_o = '0;
      for (int i = 0; i < DEPTH; i++) begin
         idx = headPtr_q + PW'(i);
         if ((CW'(i) < count_q) && (entryAddr_q[idx] == ld_addr_i)) begin
            ld_hit_o  = 1'b1;
            ld_data_o = entryData_q[idx];
         end
      end
   end

endmodule
